majority_vote_filter: RTL and testbench

- Parametrised streaming successor to the fixed 4-input, 3-of-4 majority gate.
- Accepts one N-bit sample per handshake and computes a runtime-programmable k-of-N threshold vote on that sample.
- Also produces a temporally filtered vote: a majority over the last W per-sample votes.
- Sits between redundant sensor/replica channels and downstream control logic, with valid/ready on both sides and a single registered output stage.

---
 rtl/majority_vote_filter.sv | 101 ++++++++++
 tb/tb_majority_vote_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/majority_vote_filter.sv
// Streaming k-of-N majority vote with a W-deep temporal vote window.
// One registered output stage with valid/ready on both sides.
module majority_vote_filter #(
  parameter int N      = 4,
  parameter int W      = 4,
  parameter int WIN_TH = 3,
  localparam int CW    = $clog2(N + 1),
  localparam int WCW   = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [CW-1:0] thresh,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_vote,
  output logic [CW-1:0] out_count,
  output logic          out_filt,
  output logic          out_unan,
  output logic          out_win_full
);

  logic [W-1:0]   hist;
  logic [WCW-1:0] wcount;
  logic [WCW-1:0] fill;

  logic           accept;
  logic [CW-1:0]  count;
  logic           vote;
  logic           unan;
  logic [W-1:0]   hist_base;
  logic [W-1:0]   hist_next;
  logic           dropped;
  logic [WCW-1:0] wcount_base;
  logic [WCW-1:0] wcount_next;
  logic [WCW-1:0] fill_base;
  logic [WCW-1:0] fill_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(in_data[i]);
    end
  end

  // thresh above N can never be met since count tops out at N
  assign vote = (count >= thresh);
  assign unan = (in_data == '0) || (&in_data);

  // clear takes effect before a same-cycle accept, so the new vote opens a fresh window
  assign hist_base   = clear ? '0 : hist;
  assign wcount_base = clear ? '0 : wcount;
  assign fill_base   = clear ? '0 : fill;

  assign dropped     = hist_base[W-1];
  assign hist_next   = W'({hist_base, vote});
  assign wcount_next = wcount_base + WCW'(vote) - WCW'(dropped);
  assign fill_next   = (fill_base == WCW'(W)) ? fill_base : fill_base + WCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist         <= '0;
      wcount       <= '0;
      fill         <= '0;
      out_valid    <= 1'b0;
      out_vote     <= 1'b0;
      out_count    <= '0;
      out_filt     <= 1'b0;
      out_unan     <= 1'b0;
      out_win_full <= 1'b0;
    end else begin
      if (accept) begin
        hist         <= hist_next;
        wcount       <= wcount_next;
        fill         <= fill_next;
        out_vote     <= vote;
        out_count    <= count;
        out_filt     <= (wcount_next >= WCW'(WIN_TH));
        out_unan     <= unan;
        out_win_full <= (fill_next == WCW'(W));
      end else if (clear) begin
        hist   <= '0;
        wcount <= '0;
        fill   <= '0;
      end

      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_majority_vote_filter.sv
// Directed bench for majority_vote_filter: N=4 legacy instance and an N=5 instance
// for threshold edge cases.
module tb_majority_vote_filter;

  logic clk;
  logic rst_n;

  // N=4, W=4, WIN_TH=3
  logic       a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready;
  logic [3:0] a_in_data;
  logic [2:0] a_thresh, a_out_count;
  logic       a_out_vote, a_out_filt, a_out_unan, a_out_win_full;

  // N=5, W=4, WIN_TH=3
  logic       b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready;
  logic [4:0] b_in_data;
  logic [2:0] b_thresh, b_out_count;
  logic       b_out_vote, b_out_filt, b_out_unan, b_out_win_full;

  int passed = 0;
  int total  = 0;

  majority_vote_filter #(.N(4), .W(4), .WIN_TH(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .thresh(a_thresh), .clear(a_clear),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_vote(a_out_vote), .out_count(a_out_count), .out_filt(a_out_filt),
    .out_unan(a_out_unan), .out_win_full(a_out_win_full)
  );

  majority_vote_filter #(.N(5), .W(4), .WIN_TH(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .thresh(b_thresh), .clear(b_clear),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_vote(b_out_vote), .out_count(b_out_count), .out_filt(b_out_filt),
    .out_unan(b_out_unan), .out_win_full(b_out_win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vote_tab;
  logic [15:0] unan_tab;
  logic [5:0]  win_votes;
  logic [5:0]  win_filt;
  logic [5:0]  win_full;
  logic [3:0]  thr_tab [4];
  logic        thr_vote [4];

  initial begin
    vote_tab  = 16'hE880;
    unan_tab  = 16'h8001;
    win_votes = 6'b001011;
    win_filt  = 6'b001000;
    win_full  = 6'b111000;
    thr_tab   = '{4'd0, 4'd3, 4'd4, 4'd7};
    thr_vote  = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_thresh = 3'd3; a_clear = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_thresh = 3'd0; b_clear = 0; b_out_ready = 1;

    // reset state
    tick();
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_out_vote", a_out_vote, 0);
    check("rst_out_filt", a_out_filt, 0);
    check("rst_win_full", a_out_win_full, 0);
    check("rst_in_ready", a_in_ready, 1);
    rst_n = 1'b1;
    tick();

    // legacy 3-of-4 sweep
    for (int d = 0; d < 16; d++) begin
      a_in_valid = 1; a_in_data = 4'(d); a_thresh = 3'd3;
      tick();
      check($sformatf("legacy_valid_%0d", d), a_out_valid, 1);
      check($sformatf("legacy_vote_%0d", d), a_out_vote, vote_tab[d]);
      check($sformatf("legacy_count_%0d", d), a_out_count, $countones(4'(d)));
      check($sformatf("legacy_unan_%0d", d), a_out_unan, unan_tab[d]);
    end
    a_in_valid = 0;
    tick();
    check("drain_out_valid", a_out_valid, 0);

    // threshold edges on N=5, sample 10110
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1; b_in_data = 5'b10110; b_thresh = 3'(thr_tab[i]);
      tick();
      check($sformatf("thr_vote_%0d", thr_tab[i]), b_out_vote, thr_vote[i]);
      check($sformatf("thr_count_%0d", thr_tab[i]), b_out_count, 3);
    end
    b_in_valid = 0;

    // window sequence 1,1,0,1,0,0 from a cleared window
    a_clear = 1;
    tick();
    a_clear = 0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1; a_thresh = 3'd3; a_in_data = win_votes[i] ? 4'b1111 : 4'b0000;
      tick();
      check($sformatf("win_vote_%0d", i), a_out_vote, win_votes[i]);
      check($sformatf("win_filt_%0d", i), a_out_filt, win_filt[i]);
      check($sformatf("win_full_%0d", i), a_out_win_full, win_full[i]);
    end

    // four votes of 1, then clear with a simultaneous accept
    a_in_data = 4'b1111;
    a_clear = 1;
    tick();
    a_clear = 0;
    tick(); tick(); tick();
    check("pre_clear_filt", a_out_filt, 1);
    check("pre_clear_full", a_out_win_full, 1);
    a_clear = 1;
    tick();
    a_clear = 0;
    check("clracc_valid", a_out_valid, 1);
    check("clracc_filt", a_out_filt, 0);
    check("clracc_full", a_out_win_full, 0);
    tick();
    check("clracc_next_filt", a_out_filt, 0);
    tick();
    check("clracc_third_filt", a_out_filt, 1);
    check("clracc_third_full", a_out_win_full, 0);

    // back-pressure
    a_in_valid = 0;
    tick();
    check("bp_drained", a_out_valid, 0);
    a_clear = 1;
    tick();
    a_clear = 0;
    a_out_ready = 0; a_in_valid = 1; a_in_data = 4'b0011; a_thresh = 3'd1;
    tick();
    check("bp_first_valid", a_out_valid, 1);
    check("bp_first_count", a_out_count, 2);
    check("bp_in_ready_low", a_in_ready, 0);
    a_in_data = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_hold_valid_%0d", i), a_out_valid, 1);
      check($sformatf("bp_hold_count_%0d", i), a_out_count, 2);
      check($sformatf("bp_hold_ready_%0d", i), a_in_ready, 0);
    end
    a_out_ready = 1;
    #1;
    check("bp_release_ready", a_in_ready, 1);
    tick();
    check("bp_resume_valid", a_out_valid, 1);
    check("bp_resume_count", a_out_count, 4);
    a_in_data = 4'b0001;
    tick();
    check("bp_next_valid", a_out_valid, 1);
    check("bp_next_count", a_out_count, 1);
    check("bp_next_vote", a_out_vote, 1);

    // async reset mid-cycle with a held result
    a_in_valid = 0; a_out_ready = 0;
    tick();
    check("ar_held_valid", a_out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", a_out_valid, 0);
    check("ar_count", a_out_count, 0);
    check("ar_vote", a_out_vote, 0);
    check("ar_filt", a_out_filt, 0);
    #2;
    rst_n = 1'b1;
    a_out_ready = 1; a_in_valid = 1; a_in_data = 4'b1111; a_thresh = 3'd3;
    tick();
    a_in_valid = 0;
    check("post_rst_valid", a_out_valid, 1);
    check("post_rst_vote", a_out_vote, 1);
    check("post_rst_filt", a_out_filt, 0);
    check("post_rst_full", a_out_win_full, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
